sram_dp_be: RTL and testbench

//   Parametrised simple-dual-port SRAM for CNN feature-map and weight buffers.

---
 rtl/sram_dp_be.sv | 115 +++++++++++
 tb/tb_sram_dp_be.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_be.sv
// Simple-dual-port SRAM with byte-enable writes, pipelined reads (1 or 2
// cycles), selectable read-during-write behaviour and a hardware clear
// sequencer that zeroes every word after reset or on request.
module sram_dp_be #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 256,
  parameter int RD_LATENCY  = 1,
  parameter int WRITE_FIRST = 0,
  parameter int BE_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  port_open;
  logic                  wr_in_rng, rd_in_rng;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_word;

  // vld_pipe[k] / dat_pipe[k] hold the read result k cycles after acceptance;
  // a data stage only loads with a valid result, so the output holds its value.
  logic [RD_LATENCY:1]                 vld_pipe;
  logic [RD_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

  assign busy      = (state == ST_CLEAR);
  // clear_req wins over both ports in the same cycle
  assign port_open = !busy && !clear_req;
  assign wr_in_rng = (32'(wr_addr) < DEPTH);
  assign rd_in_rng = (32'(rd_addr) < DEPTH);
  assign wr_acc    = port_open && wr_en && wr_in_rng;
  assign rd_acc    = port_open && rd_en;

  // Clear sequencer: walk clr_cnt over the whole array, then open the ports
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == CLR_LAST) state <= ST_IDLE;
        end
        default: begin
          if (clear_req) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  // Array write port: zeroing during clear, otherwise byte-masked writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[clr_cnt] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < BE_WIDTH; i++)
          if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read sample: old word, or old word merged with enabled write bytes when bypassing
  always_comb begin
    rd_word = '0;
    if (rd_in_rng) begin
      rd_word = mem[rd_addr];
      if (WRITE_FIRST != 0 && wr_acc && wr_addr == rd_addr) begin
        for (int i = 0; i < BE_WIDTH; i++)
          if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  // Read pipeline: only reset flushes it; a clear lets in-flight reads finish
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      if (rd_acc) dat_pipe[1] <= rd_word;
      for (int k = 2; k <= RD_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign rd_valid = vld_pipe[RD_LATENCY];
  assign rd_data  = dat_pipe[RD_LATENCY];

endmodule

// File: tb/tb_sram_dp_be.sv
// Bench for sram_dp_be: four instances (latency 1/2, read-old/write-first,
// full and partial depth) share one stimulus stream and are compared against
// a word-array + pending-read-queue reference model.
module tb_sram_dp_be;

  logic        clk = 1'b0;
  logic        rst, clear_req, wr_en, rd_en;
  logic [7:0]  wr_addr, rd_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;

  logic        busy_o     [4];
  logic        rd_valid_o [4];
  logic [15:0] rd_data_o  [4];

  always #5 clk = ~clk;

  sram_dp_be #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256), .RD_LATENCY(1), .WRITE_FIRST(0)) u_dut0 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_o[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]));
  sram_dp_be #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256), .RD_LATENCY(1), .WRITE_FIRST(1)) u_dut1 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_o[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]));
  sram_dp_be #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256), .RD_LATENCY(2), .WRITE_FIRST(0)) u_dut2 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_o[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[2]), .rd_valid(rd_valid_o[2]));
  sram_dp_be #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(200), .RD_LATENCY(1), .WRITE_FIRST(1)) u_dut3 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_o[3]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[3]), .rd_valid(rd_valid_o[3]));

  function automatic int lat(int d); return (d == 2) ? 2 : 1; endfunction
  function automatic bit wf(int d);  return (d == 1) || (d == 3); endfunction
  function automatic int dep(int d); return (d == 3) ? 200 : 256; endfunction

  function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] wd, logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = wd[7:0];
    if (be[1]) r[15:8] = wd[15:8];
    return r;
  endfunction

  // reference model state
  typedef struct {int dut; int due; logic [15:0] data;} rd_item_t;
  rd_item_t    rq[$];
  logic [15:0] mmem [4][256];
  int          clr_left [4];
  int          clr_idx  [4];
  logic        exp_v [4];
  logic [15:0] exp_d [4];
  int          cyc_n = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic idle_inputs();
    clear_req = 0; wr_en = 0; rd_en = 0;
    wr_addr = 0; rd_addr = 0; wr_be = 0; wr_data = 0;
  endtask

  // advance the model with the current inputs, then clock the DUTs
  task automatic clk_step();
    bit was_rst;
    logic [15:0] rv;
    rd_item_t it;
    was_rst = rst;
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        clr_left[d] = dep(d); clr_idx[d] = 0;
        for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].dut == d) rq.delete(i);
      end else if (clr_left[d] > 0) begin
        mmem[d][clr_idx[d]] = '0;
        clr_idx[d]++; clr_left[d]--;
      end else if (clear_req) begin
        clr_left[d] = dep(d); clr_idx[d] = 0;
      end else begin
        if (rd_en) begin
          rv = '0;
          if (int'(rd_addr) < dep(d)) begin
            rv = mmem[d][rd_addr];
            if (wf(d) && wr_en && wr_addr == rd_addr) rv = merge(rv, wr_data, wr_be);
          end
          it.dut = d; it.due = cyc_n + lat(d); it.data = rv;
          rq.push_back(it);
        end
        if (wr_en && int'(wr_addr) < dep(d))
          mmem[d][wr_addr] = merge(mmem[d][wr_addr], wr_data, wr_be);
      end
    end
    cyc_n++;
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) begin
      if (was_rst) begin
        exp_v[d] = 0; exp_d[d] = '0;
      end else begin
        exp_v[d] = 0;
        for (int i = rq.size() - 1; i >= 0; i--)
          if (rq[i].dut == d && rq[i].due == cyc_n) begin
            exp_v[d] = 1; exp_d[d] = rq[i].data; rq.delete(i);
          end
      end
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] v, input logic [1:0] be);
    wr_en = 1; wr_addr = a; wr_data = v; wr_be = be;
    clk_step();
    wr_en = 0;
  endtask

  task automatic do_read(input logic [7:0] a);
    rd_en = 1; rd_addr = a;
    clk_step();
    rd_en = 0;
  endtask

  task automatic test_reset();
    int n, b3;
    idle_inputs();
    rst = 1; clk_step(); rst = 0;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (busy_o[d] !== 1'b1 || rd_valid_o[d] !== 1'b0 || rd_data_o[d] !== 16'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: busy=%b valid=%b data=%h, want busy=1 valid=0 data=0000",
                 d, busy_o[d], rd_valid_o[d], rd_data_o[d]);
      end
    end
    n = 0; b3 = -1;
    while (busy_o[0] === 1'b1 && n < 400) begin
      clk_step(); n++;
      if (busy_o[3] === 1'b0 && b3 < 0) b3 = n;
    end
    checks++;
    if (n != 256) begin errors++; $display("FAIL clear_len_256: got %0d cycles want 256", n); end
    checks++;
    if (b3 != 200) begin errors++; $display("FAIL clear_len_200: got %0d cycles want 200", b3); end
    do_read(8'h10);
    checks++;
    if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== 16'h0000 || rd_valid_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL read_after_clear_l1: valid=%b data=%h l2valid=%b, want 1 0000 0",
               rd_valid_o[0], rd_data_o[0], rd_valid_o[2]);
    end
    clk_step();
    checks++;
    if (rd_valid_o[2] !== 1'b1 || rd_data_o[2] !== 16'h0000 || rd_valid_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL read_after_clear_l2: valid=%b data=%h l1valid=%b, want 1 0000 0",
               rd_valid_o[2], rd_data_o[2], rd_valid_o[0]);
    end
  endtask

  task automatic test_byte_enable();
    logic [15:0] want [3];
    logic [1:0]  bes  [3];
    logic [15:0] vals [3];
    want = '{16'hABCD, 16'hAB34, 16'hAB34};
    bes  = '{2'b11, 2'b01, 2'b00};
    vals = '{16'hABCD, 16'h1234, 16'hFFFF};
    for (int s = 0; s < 3; s++) begin
      do_write(8'h05, vals[s], bes[s]);
      do_read(8'h05);
      checks++;
      if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== want[s]) begin
        errors++;
        $display("FAIL byte_enable step%0d: valid=%b data=%h, want 1 %h", s, rd_valid_o[0], rd_data_o[0], want[s]);
      end
    end
  endtask

  task automatic test_read_during_write();
    do_write(8'h07, 16'h1111, 2'b11);
    wr_en = 1; wr_addr = 8'h07; wr_data = 16'h2222; wr_be = 2'b11;
    rd_en = 1; rd_addr = 8'h07;
    clk_step();
    idle_inputs();
    checks++;
    if (rd_data_o[0] !== 16'h1111 || rd_valid_o[0] !== 1'b1) begin
      errors++; $display("FAIL rdw_read_first: data=%h valid=%b, want 1111 1", rd_data_o[0], rd_valid_o[0]);
    end
    checks++;
    if (rd_data_o[1] !== 16'h2222 || rd_valid_o[1] !== 1'b1) begin
      errors++; $display("FAIL rdw_write_first: data=%h valid=%b, want 2222 1", rd_data_o[1], rd_valid_o[1]);
    end
    do_read(8'h07);
    checks++;
    if (rd_data_o[0] !== 16'h2222) begin
      errors++; $display("FAIL rdw_after: data=%h, want 2222", rd_data_o[0]);
    end
  endtask

  task automatic test_latency2();
    logic        wv [5];
    logic [15:0] wd [5];
    wv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    wd = '{16'h0000, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A3};
    do_write(8'h01, 16'h00A1, 2'b11);
    do_write(8'h02, 16'h00A2, 2'b11);
    do_write(8'h03, 16'h00A3, 2'b11);
    clk_step();
    for (int s = 0; s < 5; s++) begin
      rd_en = (s < 3); rd_addr = 8'(s + 1);
      clk_step();
      checks++;
      if (rd_valid_o[2] !== wv[s] || (wv[s] && rd_data_o[2] !== wd[s])) begin
        errors++;
        $display("FAIL latency2 t+%0d: valid=%b data=%h, want %b %h", s + 1, rd_valid_o[2], rd_data_o[2], wv[s], wd[s]);
      end
    end
    checks++;
    if (rd_data_o[2] !== 16'h00A3) begin
      errors++; $display("FAIL latency2_hold: data=%h, want 00a3", rd_data_o[2]);
    end
    rd_en = 0;
  endtask

  task automatic test_clear();
    int viol, n;
    do_write(8'h09, 16'h5555, 2'b11);
    do_read(8'h09);
    clear_req = 1; wr_en = 1; wr_addr = 8'h09; wr_data = 16'h7777; wr_be = 2'b11;
    clk_step();
    idle_inputs();
    checks++;
    if (rd_valid_o[2] !== 1'b1 || rd_data_o[2] !== 16'h5555 || busy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL clear_inflight: valid=%b data=%h busy=%b, want 1 5555 1", rd_valid_o[2], rd_data_o[2], busy_o[0]);
    end
    viol = 0;
    for (int c = 0; c < 100; c++) begin
      rd_en = 1; rd_addr = 8'($urandom_range(0, 255));
      clk_step();
      for (int d = 0; d < 3; d++) if (rd_valid_o[d] !== 1'b0 || busy_o[d] !== 1'b1) viol++;
    end
    rst = 1; clk_step(); rst = 0;
    n = 0;
    while (busy_o[0] === 1'b1 && n < 400) begin
      rd_en = 1; rd_addr = 8'($urandom_range(0, 255));
      clk_step(); n++;
      for (int d = 0; d < 3; d++) if (rd_valid_o[d] !== 1'b0) viol++;
    end
    rd_en = 0;
    checks++;
    if (viol != 0) begin errors++; $display("FAIL busy_reads: got %0d stray strobes want 0", viol); end
    checks++;
    if (n != 256) begin errors++; $display("FAIL clear_restart: busy %0d cycles want 256", n); end
    do_read(8'h09);
    checks++;
    if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== 16'h0000) begin
      errors++; $display("FAIL clear_dropped_write: valid=%b data=%h, want 1 0000", rd_valid_o[0], rd_data_o[0]);
    end
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 8'($urandom_range(0, 255));
      1: return 8'($urandom_range(190, 255));
      default: return 8'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      clear_req = ($urandom_range(0, 499) == 0);
      wr_en = $urandom_range(0, 1); wr_addr = rand_addr();
      wr_be = 2'($urandom_range(0, 3)); wr_data = 16'($urandom);
      rd_en = $urandom_range(0, 1);
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : rand_addr();
      clk_step();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (busy_o[d] !== (clr_left[d] > 0) || rd_valid_o[d] !== exp_v[d] || rd_data_o[d] !== exp_d[d]) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: busy=%b valid=%b data=%h, want %b %b %h", d, cyc_n,
                   busy_o[d], rd_valid_o[d], rd_data_o[d], clr_left[d] > 0, exp_v[d], exp_d[d]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_byte_enable();
    test_read_during_write();
    test_latency2();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
